// File: rtl/sar_adc.sv
// Successive-approximation ADC controller driving an external 8-bit DAC and comparator.
// Latency: result/valid appear 8*SETTLE+1 cycles after start is accepted.
// Backpressure: none; start is ignored while busy and accepted again in the valid cycle.
module sar_adc #(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       comp,
    output logic [7:0] dac_code,
    output logic [7:0] result,
    output logic       busy,
    output logic       valid
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

    state_t     state, state_n;
    logic [2:0] bit_q, bit_n;
    logic [7:0] cnt_q, cnt_n;
    logic [7:0] dac_n;
    logic [7:0] res_n;
    logic       vld_n;

    logic [7:0] trial_mask;
    logic [7:0] decided;

    // Trial bit is kept only when the comparator says the input is at or above the DAC level.
    assign trial_mask = 8'd1 << bit_q;
    assign decided    = comp ? dac_code : (dac_code & ~trial_mask);
    assign busy       = (state == CONV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_q    <= 3'd7;
            cnt_q    <= 8'd0;
            dac_code <= 8'h00;
            result   <= 8'h00;
            valid    <= 1'b0;
        end else begin
            state    <= state_n;
            bit_q    <= bit_n;
            cnt_q    <= cnt_n;
            dac_code <= dac_n;
            result   <= res_n;
            valid    <= vld_n;
        end
    end

    always_comb begin
        state_n = state;
        bit_n   = bit_q;
        cnt_n   = cnt_q;
        dac_n   = dac_code;
        res_n   = result;
        vld_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CONV;
                    dac_n   = 8'h80;
                    bit_n   = 3'd7;
                    cnt_n   = 8'd0;
                end
            end
            CONV: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_n = 8'd0;
                    if (bit_q != 3'd0) begin
                        // Resolve this bit and raise the next lower trial bit on the same edge.
                        dac_n = decided | (trial_mask >> 1);
                        bit_n = bit_q - 3'd1;
                    end else begin
                        dac_n   = decided;
                        res_n   = decided;
                        vld_n   = 1'b1;
                        bit_n   = 3'd7;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_adc.sv
// Scoreboarded bench for sar_adc: two instances (SETTLE=4 and SETTLE=1) with an ideal DAC/comparator model.
module tb_sar_adc;

    typedef struct {
        logic [7:0] code;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst4, start4, comp4, busy4, valid4;
    logic [7:0] dac4, res4;
    logic       rst1, start1, comp1, busy1, valid1;
    logic [7:0] dac1, res1;

    real  vin4 = 0.0, vin1 = 0.0;
    bit   noise4 = 0, noise1 = 0;
    bit   aborted4 = 0;
    bit   pbusy4 = 0, pbusy1 = 0;
    int   ph4 = 0, ph1 = 0;
    int   blen4 = 0, blen1 = 0;
    int   cyc = 0;
    int   errors = 0, checks = 0;
    exp_t q4[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sar_adc #(.SETTLE(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .comp(comp4),
        .dac_code(dac4), .result(res4), .busy(busy4), .valid(valid4)
    );

    sar_adc #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .comp(comp1),
        .dac_code(dac1), .result(res1), .busy(busy1), .valid(valid1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic real dac_v(input logic [7:0] c);
        real a;
        a = 0.0;
        for (int i = 0; i < 8; i++)
            if (c[i]) a += 3.3 * real'(1 << i) / 256.0;
        return a;
    endfunction

    // Ideal converter: largest code whose DAC level does not exceed vin.
    function automatic logic [7:0] ref_code(input real v);
        real x;
        x = v * 256.0 / 3.3;
        if (x >= 255.0) return 8'hFF;
        if (x <= 0.0) return 8'h00;
        return 8'($rtoi(x));
    endfunction

    function automatic real pick_vin();
        int c;
        c = $urandom_range(0, 255);
        return (real'(c) + 0.5) * 3.3 / 256.0;
    endfunction

    // Comparator model; optional noise only on cycles whose comp sample is not a decision.
    always @(negedge clk) begin
        int  tbit;
        logic [7:0] lowmask;
        ph4 = busy4 ? (pbusy4 ? ph4 + 1 : 0) : 0;
        pbusy4 = busy4;
        ph1 = busy1 ? (pbusy1 ? ph1 + 1 : 0) : 0;
        pbusy1 = busy1;
        comp4 = (vin4 >= dac_v(dac4)) ^
                (noise4 && (!busy4 || ((ph4 + 1) % 4 != 0)) && ($urandom_range(0, 1) == 1));
        comp1 = (vin1 >= dac_v(dac1)) ^
                (noise1 && (!busy1 || ((ph1 + 1) % 1 != 0)) && ($urandom_range(0, 1) == 1));
        if (busy4) begin
            tbit = 7 - ph4 / 4;
            if (tbit < 0) tbit = 0;
            lowmask = (8'd1 << tbit) - 8'd1;
            chk("dac4_trial_bit_set", int'(dac4[tbit]), 1);
            chk("dac4_low_bits_zero", int'(dac4 & lowmask), 0);
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (valid4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid4_unexpected: got valid with result 0x%0h, required no pulse", res4);
            end else begin
                e = q4.pop_front();
                chk("res4", res4, e.code);
                chk("dac4_final", dac4, e.code);
                chk("valid4_cycle", cyc, e.cyc);
            end
        end
        if (valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid1_unexpected: got valid with result 0x%0h, required no pulse", res1);
            end else begin
                e = q1.pop_front();
                chk("res1", res1, e.code);
                chk("dac1_final", dac1, e.code);
                chk("valid1_cycle", cyc, e.cyc);
            end
        end
        if (busy4) blen4++;
        else if (blen4 != 0) begin
            if (!aborted4) chk("busy4_len", blen4, 32);
            blen4 = 0;
            aborted4 = 0;
        end
        if (busy1) blen1++;
        else if (blen1 != 0) begin
            chk("busy1_len", blen1, 8);
            blen1 = 0;
        end
    end

    task automatic convert4(input real v);
        @(negedge clk);
        vin4 = v;
        start4 = 1'b1;
        q4.push_back('{ref_code(v), cyc + 1 + 32});
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_idle4();
        int n;
        n = 0;
        while ((q4.size() != 0 || busy4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait4_within_budget", int'(n < 200), 1);
    endtask

    initial begin
        int e0;
        rst4 = 1'b1; rst1 = 1'b1;
        start4 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy4", busy4, 0);
        chk("rst_valid4", valid4, 0);
        chk("rst_dac4", dac4, 0);
        chk("rst_res4", res4, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_res1", res1, 0);
        rst4 = 1'b0; rst1 = 1'b0;

        convert4(1.0);
        wait_idle4();
        chk("vin_1v0_result", res4, 8'h4D);
        chk("vin_1v0_dac", dac4, 8'h4D);

        convert4(3.3);
        wait_idle4();
        chk("vin_3v3_result", res4, 8'hFF);

        // Zero input: every trial bit is rejected, so the DAC walks a single one down.
        convert4(0.0);
        for (int k = 0; k < 8; k++) begin
            chk("vin_0_trial_seq", dac4, 8'h80 >> k);
            repeat (4) @(negedge clk);
        end
        wait_idle4();
        chk("vin_0_result", res4, 8'h00);

        // Start re-pulsed during a conversion must be ignored.
        convert4(pick_vin());
        repeat (4) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (14) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_idle4();
        repeat (40) @(negedge clk);

        noise4 = 1;
        for (int i = 0; i < 6; i++) begin
            convert4(pick_vin());
            wait_idle4();
        end
        noise4 = 0;

        // Reset in the middle of the bit-4 trial discards the conversion.
        convert4(1.0);
        wait_idle4();
        convert4(pick_vin());
        e0 = cyc;
        repeat (13) @(negedge clk);
        chk("mid_cycle_reached", cyc, e0 + 13);
        chk("mid_bit4_set", dac4[4], 1);
        aborted4 = 1;
        rst4 = 1'b1;
        q4.delete();
        @(negedge clk);
        chk("abort_busy4", busy4, 0);
        chk("abort_dac4", dac4, 0);
        chk("abort_res4", res4, 0);
        chk("abort_valid4", valid4, 0);
        rst4 = 1'b0;
        repeat (40) @(negedge clk);
        convert4(pick_vin());
        wait_idle4();

        // Back-to-back conversions with start held high on the SETTLE=1 instance.
        noise1 = 1;
        @(negedge clk);
        start1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            vin1 = pick_vin();
            q1.push_back('{ref_code(vin1), cyc + 1 + 8});
            repeat (9) @(negedge clk);
        end
        start1 = 1'b0;
        noise1 = 0;
        repeat (20) @(negedge clk);

        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
